// File: rtl/inst_cache_pkg.sv
// Shared types and geometry constants for the direct-mapped instruction cache.
package inst_cache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam int ADDR_W        = 32;
    localparam int WORD_W        = 32;
    localparam int BYTE_OFFSET_W = 2;
    localparam int COUNT_W       = 16;

    localparam int DEFAULT_NUM_SETS    = 16;
    localparam int DEFAULT_BLOCK_WORDS = 4;

    // Tag width is whatever is left of the address above the index field.
    function automatic int tag_width(input int num_sets, input int block_words);
        return ADDR_W - BYTE_OFFSET_W - $clog2(num_sets) - $clog2(block_words);
    endfunction

    localparam int DEFAULT_OFFSET_W = $clog2(DEFAULT_BLOCK_WORDS);
    localparam int DEFAULT_INDEX_W  = $clog2(DEFAULT_NUM_SETS);
    localparam int DEFAULT_TAG_W    = tag_width(DEFAULT_NUM_SETS, DEFAULT_BLOCK_WORDS);

endpackage

// File: rtl/inst_cache_line_store.sv
// Tag, valid and data arrays for the cache lines: one write port, one
// combinational read port, a single-line invalidate and a bulk invalidate.
module inst_cache_line_store
    import inst_cache_pkg::*;
#(
    parameter int NUM_SETS    = DEFAULT_NUM_SETS,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int INDEX_W     = DEFAULT_INDEX_W,
    parameter int OFFSET_W    = DEFAULT_OFFSET_W,
    parameter int TAG_W       = DEFAULT_TAG_W
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                invalidate_all,
    input  logic                clear_en,
    input  logic [INDEX_W-1:0]  clear_idx,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_idx,
    input  logic [OFFSET_W-1:0] wr_word,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic                wr_fill_done,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [INDEX_W-1:0]  rd_idx,
    input  logic [OFFSET_W-1:0] rd_word,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [WORD_W-1:0]   rd_data
);

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [TAG_W-1:0]    tag_d  [NUM_SETS];
    logic [WORD_W-1:0]   data_q [NUM_SETS][BLOCK_WORDS];
    logic [WORD_W-1:0]   data_d [NUM_SETS][BLOCK_WORDS];

    // Valid bits: bulk invalidate dominates, otherwise a line is cleared when its refill starts and set by its last word.
    always_comb begin
        valid_d = valid_q;
        if (invalidate_all) begin
            valid_d = '0;
        end else begin
            if (clear_en) begin
                valid_d[clear_idx] = 1'b0;
            end
            if (wr_en && wr_fill_done) begin
                valid_d[wr_idx] = 1'b1;
            end
        end
    end

    // Tag is recorded together with the last word so a partially filled line never carries a matching tag and valid bit.
    always_comb begin
        tag_d = tag_q;
        if (wr_en && wr_fill_done) begin
            tag_d[wr_idx] = wr_tag;
        end
    end

    // Each refill beat writes one word of the addressed line.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            data_d[wr_idx][wr_word] = wr_data;
        end
    end

    // Only the valid bits need a defined reset value.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage carry no reset; stale contents are masked by valid.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_word];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with zero-latency hits and a blocking,
// word-per-cycle refill from an asynchronous-read instruction memory.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int NUM_SETS    = DEFAULT_NUM_SETS,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [31:0]     inst_addr,
    input  logic            fetch_en,
    input  logic            flush,
    output logic [31:0]     inst,
    output logic            ready,
    output logic [31:0]     imem_addr,
    input  logic [0:3][7:0] imem_data,
    output logic [15:0]     hit_count,
    output logic [15:0]     miss_count
);

    localparam int OFFSET_W  = $clog2(BLOCK_WORDS);
    localparam int INDEX_W   = $clog2(NUM_SETS);
    localparam int TAG_W     = tag_width(NUM_SETS, BLOCK_WORDS);
    localparam int INDEX_LSB = BYTE_OFFSET_W + OFFSET_W;
    localparam int TAG_LSB   = INDEX_LSB + INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(BLOCK_WORDS - 1);

    state_t               state_q, state_d;
    logic [OFFSET_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [COUNT_W-1:0]   hit_count_q, hit_count_d;
    logic [COUNT_W-1:0]   miss_count_q, miss_count_d;

    logic [OFFSET_W-1:0]  req_offset;
    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;
    logic                 line_valid;
    logic [TAG_W-1:0]     line_tag;
    logic [WORD_W-1:0]    line_word;
    logic                 tag_match;
    logic                 refill_last;
    logic                 lookup_hit;
    logic                 lookup_miss;
    logic                 refill_step;
    logic [WORD_W-1:0]    fill_word;

    assign req_offset  = inst_addr[INDEX_LSB-1:BYTE_OFFSET_W];
    assign req_index   = inst_addr[TAG_LSB-1:INDEX_LSB];
    assign req_tag     = inst_addr[ADDR_W-1:TAG_LSB];
    assign tag_match   = line_valid && (line_tag == req_tag);
    assign refill_last = (cnt_q == LAST_WORD);
    assign fill_word   = {imem_data[0], imem_data[1], imem_data[2], imem_data[3]};

    inst_cache_line_store #(
        .NUM_SETS    (NUM_SETS),
        .BLOCK_WORDS (BLOCK_WORDS),
        .INDEX_W     (INDEX_W),
        .OFFSET_W    (OFFSET_W),
        .TAG_W       (TAG_W)
    ) u_line_store (
        .clk            (clk),
        .rst_b          (rst_b),
        .invalidate_all (flush),
        .clear_en       (lookup_miss),
        .clear_idx      (req_index),
        .wr_en          (refill_step),
        .wr_idx         (base_q[TAG_LSB-1:INDEX_LSB]),
        .wr_word        (cnt_q),
        .wr_data        (fill_word),
        .wr_fill_done   (refill_last),
        .wr_tag         (base_q[ADDR_W-1:TAG_LSB]),
        .rd_idx         (req_index),
        .rd_word        (req_offset),
        .rd_valid       (line_valid),
        .rd_tag         (line_tag),
        .rd_data        (line_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush always returns to IDLE, a miss starts a refill, the last beat ends it.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (lookup_miss) state_d = REFILL;
                REFILL:  if (refill_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs and control strobes: lookups only happen in IDLE and a flush cycle suppresses all activity.
    always_comb begin
        ready       = 1'b0;
        inst        = '0;
        imem_addr   = {inst_addr[31:2], 2'b00};
        lookup_hit  = 1'b0;
        lookup_miss = 1'b0;
        refill_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_en && !flush) begin
                    lookup_hit  = tag_match;
                    lookup_miss = !tag_match;
                end
                ready = lookup_hit;
                inst  = lookup_hit ? line_word : '0;
            end
            REFILL: begin
                imem_addr   = base_q + ADDR_W'({cnt_q, 2'b00});
                refill_step = !flush;
            end
            default: ;
        endcase
    end

    // Refill bookkeeping and saturating statistics counters.
    always_comb begin
        cnt_d        = cnt_q;
        base_d       = base_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (lookup_miss) begin
            cnt_d  = '0;
            base_d = {inst_addr[ADDR_W-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
            if (miss_count_q != '1) begin
                miss_count_d = miss_count_q + COUNT_W'(1);
            end
        end
        if (refill_step) begin
            cnt_d = cnt_q + OFFSET_W'(1);
        end
        if (lookup_hit && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + COUNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q        <= '0;
            base_q       <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios with literal
// expectations, then random fetch/flush traffic against a block-level model.
module tb_inst_cache;

    localparam int NUM_SETS    = 16;
    localparam int BLOCK_WORDS = 4;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic [31:0]     inst_addr = '0;
    logic            fetch_en = 1'b0;
    logic            flush = 1'b0;
    logic [31:0]     inst;
    logic            ready;
    logic [31:0]     imem_addr;
    logic [0:3][7:0] imem_data;
    logic [15:0]     hit_count;
    logic [15:0]     miss_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: which block is resident in each set, plus the refill in flight.
    bit          m_valid [NUM_SETS];
    logic [23:0] m_tag   [NUM_SETS];
    int          m_left;
    logic [31:0] m_base;
    int          m_hits;
    int          m_misses;

    inst_cache #(.NUM_SETS(NUM_SETS), .BLOCK_WORDS(BLOCK_WORDS)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .inst_addr  (inst_addr),
        .fetch_en   (fetch_en),
        .flush      (flush),
        .inst       (inst),
        .ready      (ready),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: word at 0x40+4k is 0x1000_0000+k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2) - 32'd16;
    endfunction

    logic [31:0] mem_rd;
    assign mem_rd = mem_word(imem_addr);
    assign imem_data[0] = mem_rd[31:24];
    assign imem_data[1] = mem_rd[23:16];
    assign imem_data[2] = mem_rd[15:8];
    assign imem_data[3] = mem_rd[7:0];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit model_hit();
        return (m_left == 0) && (fetch_en === 1'b1) && (flush === 1'b0)
            && m_valid[inst_addr[7:4]] && (m_tag[inst_addr[7:4]] == inst_addr[31:8]);
    endfunction

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_left   = 0;
        m_base   = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_step();
        int s;
        if (flush) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_left = 0;
        end else if (m_left == 0) begin
            if (fetch_en) begin
                s = int'(inst_addr[7:4]);
                if (m_valid[s] && m_tag[s] == inst_addr[31:8]) begin
                    if (m_hits < 65535) m_hits++;
                end else begin
                    if (m_misses < 65535) m_misses++;
                    m_valid[s] = 1'b0;
                    m_base = {inst_addr[31:4], 4'h0};
                    m_left = BLOCK_WORDS;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_valid[m_base[7:4]] = 1'b1;
                m_tag[m_base[7:4]]   = m_base[31:8];
            end
        end
    endtask

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) model_reset();
        else model_step();
    end

    task automatic check_output();
        bit h;
        logic [31:0] exp_imem;
        h = model_hit();
        exp_imem = (m_left == 0) ? {inst_addr[31:2], 2'b00}
                                 : m_base + 32'(4 * (BLOCK_WORDS - m_left));
        check("ready", 32'(ready), 32'(h));
        check("inst", inst, h ? mem_word(inst_addr) : 32'h0);
        check("imem_addr", imem_addr, exp_imem);
        check("hit_count", 32'(hit_count), 32'(m_hits));
        check("miss_count", 32'(miss_count), 32'(m_misses));
    endtask

    always @(negedge clk) begin
        if (rst_b) check_output();
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic fe, input logic fl);
        inst_addr = a;
        fetch_en  = fe;
        flush     = fl;
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit got;
        logic [31:0] ra;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_inst", inst, 32'h0);
        check("reset_hits", 32'(hit_count), 32'd0);
        check("reset_misses", 32'(miss_count), 32'd0);
        rst_b = 1'b1;

        // First fetch of 0x40: detection cycle, four refill beats, then hit.
        apply_stimulus(32'h40, 1'b1, 1'b0);
        #3;
        check("detect_ready", 32'(ready), 32'd0);
        check("detect_imem", imem_addr, 32'h40);
        next_cycle();
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            #3;
            check("refill_ready", 32'(ready), 32'd0);
            check("refill_imem", imem_addr, 32'h40 + 32'(4 * k));
            next_cycle();
        end
        #3;
        check("first_hit_ready", 32'(ready), 32'd1);
        check("first_hit_inst", inst, 32'h1000_0000);
        check("first_miss_count", 32'(miss_count), 32'd1);
        check("first_hit_count", 32'(hit_count), 32'd0);
        next_cycle();

        apply_stimulus(32'h4C, 1'b1, 1'b0);
        #3;
        check("same_line_ready", 32'(ready), 32'd1);
        check("same_line_inst", inst, 32'h1000_0003);
        check("same_line_hits", 32'(hit_count), 32'd1);
        next_cycle();
        apply_stimulus(32'h0, 1'b0, 1'b0);
        #3;
        check("idle_hits", 32'(hit_count), 32'd2);
        check("idle_ready", 32'(ready), 32'd0);
        check("idle_inst", inst, 32'h0);
        next_cycle();

        // Conflict on index 4: 0x140 evicts 0x40, then 0x40 misses again.
        apply_stimulus(32'h140, 1'b1, 1'b0);
        #3;
        check("conflict_miss_ready", 32'(ready), 32'd0);
        repeat (BLOCK_WORDS + 1) next_cycle();
        #3;
        check("conflict_hit_ready", 32'(ready), 32'd1);
        check("conflict_hit_inst", inst, 32'h1000_0040);
        check("conflict_misses", 32'(miss_count), 32'd2);
        next_cycle();
        apply_stimulus(32'h40, 1'b1, 1'b0);
        #3;
        check("evicted_ready", 32'(ready), 32'd0);
        repeat (BLOCK_WORDS + 1) next_cycle();
        #3;
        check("reload_ready", 32'(ready), 32'd1);
        check("reload_inst", inst, 32'h1000_0000);
        check("reload_misses", 32'(miss_count), 32'd3);
        next_cycle();

        // Flush while the line is valid, then flush mid-refill.
        apply_stimulus(32'h40, 1'b1, 1'b1);
        #3;
        check("flush_cycle_ready", 32'(ready), 32'd0);
        next_cycle();
        apply_stimulus(32'h40, 1'b1, 1'b0);
        #3;
        check("post_flush_ready", 32'(ready), 32'd0);
        next_cycle();
        next_cycle();
        apply_stimulus(32'h40, 1'b1, 1'b1);
        #3;
        check("mid_refill_flush_ready", 32'(ready), 32'd0);
        next_cycle();
        apply_stimulus(32'h40, 1'b0, 1'b0);
        #3;
        check("aborted_refill_imem", imem_addr, 32'h40);
        check("aborted_refill_misses", 32'(miss_count), 32'd4);
        next_cycle();
        apply_stimulus(32'h40, 1'b1, 1'b0);
        #3;
        check("aborted_line_invalid", 32'(ready), 32'd0);
        repeat (BLOCK_WORDS + 1) next_cycle();
        #3;
        check("refetch_ready", 32'(ready), 32'd1);
        check("refetch_misses", 32'(miss_count), 32'd5);
        next_cycle();

        // Asynchronous reset in the second refill cycle.
        apply_stimulus(32'h0, 1'b0, 1'b1);
        next_cycle();
        apply_stimulus(32'h40, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        #3;
        rst_b = 1'b0;
        #1;
        check("async_reset_ready", 32'(ready), 32'd0);
        check("async_reset_hits", 32'(hit_count), 32'd0);
        check("async_reset_misses", 32'(miss_count), 32'd0);
        next_cycle();
        rst_b = 1'b1;
        #3;
        check("after_reset_detect", 32'(ready), 32'd0);
        next_cycle();
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            #3;
            check("after_reset_refill", 32'(ready), 32'd0);
            next_cycle();
        end
        #3;
        check("after_reset_hit", 32'(ready), 32'd1);
        check("after_reset_misses", 32'(miss_count), 32'd1);
        next_cycle();

        // Random traffic over three tags to exercise hits, conflicts and flushes.
        for (int i = 0; i < 1500; i++) begin
            ra = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            apply_stimulus(ra, $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0);
            next_cycle();
        end

        // Drive the hit counter into saturation.
        apply_stimulus(32'h40, 1'b1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("sat_warmup_ready", 32'(got), 32'd1);
        next_cycle();
        repeat (65540) next_cycle();
        #3;
        check("sat_hits", 32'(hit_count), 32'h0000_FFFF);
        check("sat_ready", 32'(ready), 32'd1);
        next_cycle();
        #3;
        check("sat_hold_hits", 32'(hit_count), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
